// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: preamble/SFD hunt, nibble-to-byte assembly,
// Ethernet header capture and malformed-frame flagging.
// Ports:
//   clk, rst_n           receive clock, synchronous active-low reset
//   rgm0_en, rgm0_d      SDR nibble stream, low nibble of each byte first
//   byte_data/valid/sof  assembled bytes, sof marks first byte after SFD
//   dst_mac/src_mac      captured MAC addresses, first byte in the MSBs
//   eth_type, hdr_valid  captured EtherType, header-complete flag
//   frame_done/err/len   end-of-frame pulse with status and byte count
module rgmii_rx_deframer #(
   parameter int MIN_PREAMBLE = 7,
   parameter int MAX_FRAME    = 1518,
   parameter int LEN_W        = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rgm0_en,
   input  logic [3:0]       rgm0_d,
   output logic [7:0]       byte_data,
   output logic             byte_valid,
   output logic             byte_sof,
   output logic [47:0]      dst_mac,
   output logic [47:0]      src_mac,
   output logic [15:0]      eth_type,
   output logic             hdr_valid,
   output logic             frame_done,
   output logic             frame_err,
   output logic [LEN_W-1:0] frame_len
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DROP
   } state_t;

   localparam logic [3:0]       MIN_PRE = 4'(MIN_PREAMBLE);
   localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_FRAME);
   localparam logic [LEN_W-1:0] SAT_L   = LEN_W'(MAX_FRAME + 1);

   state_t           state_q, state_d;
   logic [3:0]       pre_cnt_q, pre_cnt_d;
   logic             nib_phase_q, nib_phase_d;
   logic [3:0]       lo_nib_q, lo_nib_d;
   logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]       byte_data_q, byte_data_d;
   logic             byte_valid_q, byte_valid_d;
   logic             byte_sof_q, byte_sof_d;
   logic [47:0]      dst_mac_q, dst_mac_d;
   logic [47:0]      src_mac_q, src_mac_d;
   logic [15:0]      eth_type_q, eth_type_d;
   logic             hdr_valid_q, hdr_valid_d;
   logic             frame_done_q, frame_done_d;
   logic             frame_err_q, frame_err_d;
   logic [LEN_W-1:0] frame_len_q, frame_len_d;
   logic [7:0]       new_byte;

   assign new_byte = {rgm0_d, lo_nib_q};

   always_comb begin
      state_d      = state_q;
      pre_cnt_d    = pre_cnt_q;
      nib_phase_d  = nib_phase_q;
      lo_nib_d     = lo_nib_q;
      byte_cnt_d   = byte_cnt_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      byte_sof_d   = 1'b0;
      dst_mac_d    = dst_mac_q;
      src_mac_d    = src_mac_q;
      eth_type_d   = eth_type_q;
      hdr_valid_d  = hdr_valid_q;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      frame_len_d  = frame_len_q;
      unique case (state_q)
         S_IDLE: begin
            if (rgm0_en) begin
               if (rgm0_d == 4'h5) begin
                  state_d   = S_PRE;
                  pre_cnt_d = 4'd1;
               end else begin
                  state_d = S_DROP;
               end
            end
         end
         S_PRE: begin
            if (!rgm0_en) begin
               state_d = S_IDLE;
            end else if (rgm0_d == 4'h5) begin
               if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
            end else if (rgm0_d == 4'hD && pre_cnt_q >= MIN_PRE) begin
               state_d     = S_DATA;
               nib_phase_d = 1'b0;
               byte_cnt_d  = '0;
               hdr_valid_d = 1'b0;
            end else begin
               state_d = S_DROP;
            end
         end
         S_DATA: begin
            if (!rgm0_en) begin
               // a dangling low nibble is simply discarded here
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
               frame_len_d  = byte_cnt_q;
               frame_err_d  = nib_phase_q
                            | (byte_cnt_q < LEN_W'(14))
                            | (byte_cnt_q > MAX_L);
            end else if (!nib_phase_q) begin
               lo_nib_d    = rgm0_d;
               nib_phase_d = 1'b1;
            end else begin
               nib_phase_d = 1'b0;
               if (byte_cnt_q < MAX_L) begin
                  byte_valid_d = 1'b1;
                  byte_data_d  = new_byte;
                  byte_sof_d   = (byte_cnt_q == '0);
                  if (byte_cnt_q < LEN_W'(6))
                     dst_mac_d = {dst_mac_q[39:0], new_byte};
                  else if (byte_cnt_q < LEN_W'(12))
                     src_mac_d = {src_mac_q[39:0], new_byte};
                  else if (byte_cnt_q < LEN_W'(14))
                     eth_type_d = {eth_type_q[7:0], new_byte};
                  if (byte_cnt_q == LEN_W'(13)) hdr_valid_d = 1'b1;
               end
               // count one past the limit so oversize stays visible
               if (byte_cnt_q != SAT_L) byte_cnt_d = byte_cnt_q + LEN_W'(1);
            end
         end
         S_DROP: begin
            if (!rgm0_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // never sync mid-frame: a live stream at reset is dropped
         state_q      <= rgm0_en ? S_DROP : S_IDLE;
         pre_cnt_q    <= '0;
         nib_phase_q  <= 1'b0;
         lo_nib_q     <= '0;
         byte_cnt_q   <= '0;
         byte_data_q  <= '0;
         byte_valid_q <= 1'b0;
         byte_sof_q   <= 1'b0;
         dst_mac_q    <= '0;
         src_mac_q    <= '0;
         eth_type_q   <= '0;
         hdr_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         frame_len_q  <= '0;
      end else begin
         state_q      <= state_d;
         pre_cnt_q    <= pre_cnt_d;
         nib_phase_q  <= nib_phase_d;
         lo_nib_q     <= lo_nib_d;
         byte_cnt_q   <= byte_cnt_d;
         byte_data_q  <= byte_data_d;
         byte_valid_q <= byte_valid_d;
         byte_sof_q   <= byte_sof_d;
         dst_mac_q    <= dst_mac_d;
         src_mac_q    <= src_mac_d;
         eth_type_q   <= eth_type_d;
         hdr_valid_q  <= hdr_valid_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         frame_len_q  <= frame_len_d;
      end
   end

   assign byte_data  = byte_data_q;
   assign byte_valid = byte_valid_q;
   assign byte_sof   = byte_sof_q;
   assign dst_mac    = dst_mac_q;
   assign src_mac    = src_mac_q;
   assign eth_type   = eth_type_q;
   assign hdr_valid  = hdr_valid_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;
   assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_rgmii_rx_deframer.sv
// Testbench for rgmii_rx_deframer: frame vector table plus reset sequence,
// bytes and end-of-frame status checked against scoreboard queues.
module tb_rgmii_rx_deframer;

   localparam int MAXF = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rgm0_en = 1'b0;
   logic [3:0]  rgm0_d = 4'h0;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_sof;
   logic [47:0] dst_mac;
   logic [47:0] src_mac;
   logic [15:0] eth_type;
   logic        hdr_valid;
   logic        frame_done;
   logic        frame_err;
   logic [10:0] frame_len;

   always #5 clk = ~clk;

   rgmii_rx_deframer #(
      .MIN_PREAMBLE(7),
      .MAX_FRAME(MAXF),
      .LEN_W(11)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rgm0_en(rgm0_en),
      .rgm0_d(rgm0_d),
      .byte_data(byte_data),
      .byte_valid(byte_valid),
      .byte_sof(byte_sof),
      .dst_mac(dst_mac),
      .src_mac(src_mac),
      .eth_type(eth_type),
      .hdr_valid(hdr_valid),
      .frame_done(frame_done),
      .frame_err(frame_err),
      .frame_len(frame_len)
   );

   typedef struct {
      logic [7:0] data;
      logic       sof;
   } exp_byte_t;

   typedef struct {
      logic        err;
      logic [10:0] len;
   } exp_done_t;

   typedef struct {
      int         npre;
      logic [3:0] sfd;
      int         nb;
      bit         odd;
      bit         good;
      bit         err;
      int         len;
      bit         hdr;
   } vec_t;

   exp_byte_t exp_q[$];
   exp_done_t done_q[$];
   int total = 0;
   int bad = 0;
   int bidx = 0;

   logic [7:0] hdr_bytes [0:13] = '{
      8'h54, 8'hff, 8'h01, 8'h21, 8'h23, 8'h24,
      8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc,
      8'h12, 8'h34
   };

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   function automatic logic [7:0] fbyte(input int i, input int seed);
      if (i < 14) return hdr_bytes[i];
      return 8'(i * 7 + seed);
   endfunction

   // scoreboard side: pop on every DUT byte / frame end
   always @(negedge clk) begin
      exp_byte_t e;
      exp_done_t d;
      if (byte_valid) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_byte got=%0h want=none", byte_data);
         end else begin
            e = exp_q.pop_front();
            if (byte_data !== e.data || byte_sof !== e.sof) begin
               bad++;
               $display("FAIL byte got=%0h/%0b want=%0h/%0b",
                        byte_data, byte_sof, e.data, e.sof);
            end
            if (e.sof) bidx = 0;
            total++;
            if (hdr_valid !== (bidx >= 13)) begin
               bad++;
               $display("FAIL hdr_rise idx=%0d got=%0b want=%0b",
                        bidx, hdr_valid, bidx >= 13);
            end
            bidx++;
         end
      end
      if (frame_done) begin
         total++;
         if (done_q.size() == 0) begin
            bad++;
            $display("FAIL extra_done got=len%0d want=none", frame_len);
         end else begin
            d = done_q.pop_front();
            if (frame_err !== d.err || frame_len !== d.len) begin
               bad++;
               $display("FAIL done got=err%0b/len%0d want=err%0b/len%0d",
                        frame_err, frame_len, d.err, d.len);
            end
         end
      end
   end

   task automatic nib(input logic [3:0] v);
      @(negedge clk);
      rgm0_en = 1'b1;
      rgm0_d  = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rgm0_en = 1'b0;
         rgm0_d  = 4'h0;
      end
   endtask

   task automatic send(input int npre, input logic [3:0] sfd, input int nb,
                       input bit odd, input bit good, input int seed);
      logic [7:0] b;
      repeat (npre) nib(4'h5);
      nib(sfd);
      for (int i = 0; i < nb; i++) begin
         b = fbyte(i, seed);
         if (good && i < MAXF) exp_q.push_back('{b, i == 0});
         nib(b[3:0]);
         nib(b[7:4]);
      end
      if (odd) nib(4'h9);
      idle(3);
   endtask

   task automatic chk_hdr(input string nm);
      chk({nm, "_dst"}, 64'(dst_mac), 64'h54ff01212324);
      chk({nm, "_src"}, 64'(src_mac), 64'h123456789abc);
      chk({nm, "_type"}, 64'(eth_type), 64'h1234);
   endtask

   vec_t vecs [11];

   initial begin
      logic [7:0] b;
      vecs[0]  = '{15, 4'hD, 50, 1'b0, 1'b1, 1'b0, 50, 1'b1};
      vecs[1]  = '{5,  4'hD, 20, 1'b0, 1'b0, 1'b0, 0,  1'b0};
      vecs[2]  = '{15, 4'hD, 20, 1'b0, 1'b1, 1'b0, 20, 1'b1};
      vecs[3]  = '{15, 4'hD, 20, 1'b1, 1'b1, 1'b1, 20, 1'b1};
      vecs[4]  = '{8,  4'hD, 10, 1'b0, 1'b1, 1'b1, 10, 1'b0};
      vecs[5]  = '{7,  4'hD, 80, 1'b0, 1'b1, 1'b1, 65, 1'b1};
      vecs[6]  = '{9,  4'hA, 20, 1'b0, 1'b0, 1'b0, 0,  1'b0};
      vecs[7]  = '{7,  4'hD, 14, 1'b0, 1'b1, 1'b0, 14, 1'b1};
      vecs[8]  = '{7,  4'hD, 64, 1'b0, 1'b1, 1'b0, 64, 1'b1};
      vecs[9]  = '{7,  4'hD, 65, 1'b0, 1'b1, 1'b1, 65, 1'b1};
      vecs[10] = '{6,  4'hD, 20, 1'b0, 1'b0, 1'b0, 0,  1'b0};

      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(byte_valid), 0);
      chk("rst_done", 64'(frame_done), 0);
      chk("rst_hdr", 64'(hdr_valid), 0);
      chk("rst_dst", 64'(dst_mac), 0);
      chk("rst_len", 64'(frame_len), 0);
      rst_n = 1'b1;
      idle(2);

      for (int v = 0; v < 11; v++) begin
         if (vecs[v].good)
            done_q.push_back('{vecs[v].err, 11'(vecs[v].len)});
         send(vecs[v].npre, vecs[v].sfd, vecs[v].nb, vecs[v].odd,
              vecs[v].good, v);
         chk($sformatf("v%0d_bytes_left", v), 64'(exp_q.size()), 0);
         chk($sformatf("v%0d_done_left", v), 64'(done_q.size()), 0);
         if (vecs[v].good) begin
            chk($sformatf("v%0d_hdr_valid", v), 64'(hdr_valid),
                64'(vecs[v].hdr));
            if (vecs[v].hdr) chk_hdr($sformatf("v%0d", v));
         end
      end

      // reset in the middle of a frame, stream still running
      repeat (15) nib(4'h5);
      nib(4'hD);
      for (int i = 0; i < 8; i++) begin
         b = fbyte(i, 99);
         exp_q.push_back('{b, i == 0});
         nib(b[3:0]);
         nib(b[7:4]);
      end
      @(negedge clk);
      rst_n   = 1'b0;
      rgm0_d  = 4'h3;
      @(negedge clk);
      chk("mid_rst_dst", 64'(dst_mac), 0);
      chk("mid_rst_hdr", 64'(hdr_valid), 0);
      chk("mid_rst_valid", 64'(byte_valid), 0);
      chk("mid_rst_bytes_left", 64'(exp_q.size()), 0);
      rst_n = 1'b1;
      for (int i = 8; i < 20; i++) begin
         b = fbyte(i, 99);
         nib(b[3:0]);
         nib(b[7:4]);
      end
      idle(3);
      chk("after_rst_dst", 64'(dst_mac), 0);

      done_q.push_back('{1'b0, 11'd30});
      send(7, 4'hD, 30, 1'b0, 1'b1, 42);
      chk("post_rst_bytes_left", 64'(exp_q.size()), 0);
      chk("post_rst_done_left", 64'(done_q.size()), 0);
      chk("post_rst_hdr_valid", 64'(hdr_valid), 1);
      chk_hdr("post_rst");

      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
